uart_tx_arbiter: RTL and testbench

- Shares the single UART transmitter among NUM_REQ byte producers, such as the SD command logger and debug dump.
- Runs on ex_clk and sits in front of the uart block: it drives that block's tx_data and ctrl inputs and reads its uart_state output.
- Arbitration is round-robin per byte, with optional multi-byte message locking.
- Because the UART runs on a divided baud clock (ex_clk/625), the start request is held until the transmitter acknowledges it by raising busy.

---
 rtl/uart_arb_pkg.sv | 18 +
 rtl/rr_picker.sv | 36 +++
 rtl/uart_tx_arbiter.sv | 167 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared types and constants for the UART transmit arbiter.
//   - arb_state_e : arbiter FSM encoding (HOLD only when UART_ARB_LOCK_EN is defined)
//   - CTRL_TX_START_BIT / STATE_TX_BUSY_BIT : bit positions in the uart ctrl/state bytes
//   - START_TIMEOUT_DEF : default ex_clk cycles allowed for the UART to raise busy
// Optional feature macro: UART_ARB_LOCK_EN (multi-byte message locking).
package uart_arb_pkg;

  localparam int CTRL_TX_START_BIT = 0;
  localparam int STATE_TX_BUSY_BIT = 0;
  localparam int START_TIMEOUT_DEF = 2048;

`ifdef UART_ARB_LOCK_EN
  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, HOLD} arb_state_e;
`else
  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT} arb_state_e;
`endif

endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin search.
//   valid   : per-requester request flags
//   ptr     : last served requester; search starts at ptr+1 and wraps
//   win_oh  : one-hot winner (0 when nothing valid)
//   win_idx : binary index of the winner
//   any     : at least one requester valid
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] win_oh,
  output logic [IW-1:0]      win_idx,
  output logic               any
);

  logic [IW-1:0] j;

  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    any     = 1'b0;
    j       = '0;
    // k=NUM_REQ lands back on ptr itself, so the last server is lowest priority
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = IW'((int'(ptr) + k) % NUM_REQ);
      if (!any && valid[j]) begin
        any       = 1'b1;
        win_oh[j] = 1'b1;
        win_idx   = j;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter between NUM_REQ byte producers.
// Round-robin per byte; with UART_ARB_LOCK_EN defined a requester keeps the
// UART from its first byte through the byte flagged req_last.
//   ex_clk, reset       : clock, synchronous active-high reset
//   req_valid/data/last : per-requester byte offer (data byte i at [8i+7:8i])
//   req_ready           : one-cycle accept pulse
//   grant               : one-hot UART owner, 0 when idle
//   tx_data, ctrl       : to the UART (ctrl bit0 = tx_start)
//   uart_state          : from the UART (bit0 = tx_busy)
//   arb_busy            : FSM not idle
//   timeout_err         : pulse when a start is abandoned
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int START_TIMEOUT = START_TIMEOUT_DEF
) (
  input  logic                 ex_clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic [7:0]           tx_data,
  output logic [7:0]           ctrl,
  input  logic [7:0]           uart_state,
  output logic                 arb_busy,
  output logic                 timeout_err
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(START_TIMEOUT);
  // Count 0..START_TIMEOUT-1 while in START; the registered error pulse then
  // lands exactly START_TIMEOUT cycles after tx_start first went high.
  localparam logic [CW-1:0] CNT_LAST = CW'(START_TIMEOUT - 1);

  arb_state_e           state_q, state_d;
  logic [IW-1:0]        ptr_q, ptr_d;
  logic [IW-1:0]        own_q, own_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [7:0]           data_q, data_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 terr_q, terr_d;
`ifdef UART_ARB_LOCK_EN
  logic                 last_q, last_d;
`endif

  logic                 tx_busy;
  logic [NUM_REQ-1:0]   pick_oh;
  logic [IW-1:0]        pick_idx;
  logic                 pick_any;
  logic                 unused_in;

  assign tx_busy   = uart_state[STATE_TX_BUSY_BIT];
  assign unused_in = ^{uart_state, req_last};

  rr_picker #(.NUM_REQ(NUM_REQ)) u_pick (
    .valid   (req_valid),
    .ptr     (ptr_q),
    .win_oh  (pick_oh),
    .win_idx (pick_idx),
    .any     (pick_any)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    own_d   = own_q;
    grant_d = grant_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    terr_d  = 1'b0;
`ifdef UART_ARB_LOCK_EN
    last_d  = last_q;
`endif
    case (state_q)
      // Never arbitrate while the UART is still shifting (e.g. after a reset).
      IDLE: if (!tx_busy && pick_any) begin
        state_d = LOAD;
        grant_d = pick_oh;
        own_d   = pick_idx;
      end
      LOAD: begin
        data_d  = req_data[{own_q, 3'b000} +: 8];
`ifdef UART_ARB_LOCK_EN
        last_d  = req_last[own_q];
`else
        ptr_d   = own_q;
`endif
        cnt_d   = '0;
        state_d = START;
      end
      START: begin
        if (tx_busy) begin
          state_d = WAIT;
        end else if (cnt_q == CNT_LAST) begin
          // Byte is dropped; a locked message is released as well.
          terr_d  = 1'b1;
          grant_d = '0;
          state_d = IDLE;
`ifdef UART_ARB_LOCK_EN
          ptr_d   = own_q;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT: if (!tx_busy) begin
`ifdef UART_ARB_LOCK_EN
        if (last_q) begin
          grant_d = '0;
          ptr_d   = own_q;
          state_d = IDLE;
        end else begin
          state_d = HOLD;
        end
`else
        grant_d = '0;
        state_d = IDLE;
`endif
      end
`ifdef UART_ARB_LOCK_EN
      HOLD: if (req_valid[own_q]) state_d = LOAD;
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ex_clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= IW'(NUM_REQ - 1);
      own_q   <= '0;
      grant_q <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      terr_q  <= 1'b0;
`ifdef UART_ARB_LOCK_EN
      last_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      own_q   <= own_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      terr_q  <= terr_d;
`ifdef UART_ARB_LOCK_EN
      last_q  <= last_d;
`endif
    end
  end

  always_comb begin
    ctrl                    = '0;
    ctrl[CTRL_TX_START_BIT] = (state_q == START);
  end

  assign req_ready   = (state_q == LOAD) ? grant_q : '0;
  assign grant       = grant_q;
  assign tx_data     = data_q;
  assign arb_busy    = (state_q != IDLE);
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed bench with requester queues, a simple UART
// responder and a scoreboard of (owner, byte) expected at each tx_start.
module tb_uart_tx_arbiter;

  localparam int NR = 4;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
  } sb_t;

  logic          ex_clk;
  logic          reset;
  logic [NR-1:0] req_valid;
  logic [8*NR-1:0] req_data;
  logic [NR-1:0] req_last;
  logic [NR-1:0] req_ready;
  logic [NR-1:0] grant;
  logic [7:0]    tx_data;
  logic [7:0]    ctrl;
  logic [7:0]    uart_state;
  logic          arb_busy;
  logic          timeout_err;

  uart_tx_arbiter #(.NUM_REQ(NR), .START_TIMEOUT(2048)) dut (
    .ex_clk      (ex_clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .grant       (grant),
    .tx_data     (tx_data),
    .ctrl        (ctrl),
    .uart_state  (uart_state),
    .arb_busy    (arb_busy),
    .timeout_err (timeout_err)
  );

  initial ex_clk = 1'b0;
  always #5 ex_clk = ~ex_clk;

  int         n_chk = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         start_cyc = 0;
  logic [8:0] src_q [NR][$];
  logic [NR-1:0] pend = '0;
  int         rdy_cnt [NR];
  sb_t        sb [$];
  logic       prev_start = 1'b0;
  // UART responder
  logic       tx_busy = 1'b0;
  logic       ack_en = 1'b1;
  int         start_lat = 5;
  int         busy_len = 20;
  int         u_phase = 0;
  int         u_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_srcs();
    for (int i = 0; i < NR; i++) begin
      req_valid[i] = (src_q[i].size() != 0);
      req_data[i*8 +: 8] = req_valid[i] ? src_q[i][0][7:0] : 8'h00;
      req_last[i] = req_valid[i] ? src_q[i][0][8] : 1'b0;
    end
    uart_state = {7'b1010101, tx_busy};
  endtask

  task automatic send(input int id, input logic [7:0] d, input logic l);
    src_q[id].push_back({l, d});
  endtask

  task automatic expect_byte(input int id, input logic [7:0] d);
    sb.push_back('{id: 2'(id), data: d});
  endtask

  task automatic step();
    logic [8:0] tmp;
    sb_t e;
    @(posedge ex_clk);
    #1;
    cyc++;
    // A byte is captured at the edge ending its ready cycle, so advance after it.
    for (int i = 0; i < NR; i++)
      if (pend[i]) begin
        tmp = src_q[i].pop_front();
        pend[i] = 1'b0;
      end
    for (int i = 0; i < NR; i++)
      if (req_ready[i]) begin
        pend[i] = 1'b1;
        rdy_cnt[i]++;
      end
    chk("grant_onehot0", 32'($onehot0(grant)), 32'd1);
    chk("ctrl_upper_zero", 32'(ctrl[7:1]), 32'd0);
    if (ctrl[0] && !prev_start) begin
      start_cyc = cyc;
      chk("sb_nonempty_at_start", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("start_grant", 32'(grant), 32'(4'b0001 << e.id));
        chk("start_tx_data", 32'(tx_data), 32'(e.data));
      end
    end
    prev_start = ctrl[0];
    case (u_phase)
      0: if (ctrl[0] && ack_en) begin u_phase = 1; u_cnt = start_lat; end
      1: if (u_cnt == 0) begin tx_busy = 1'b1; u_phase = 2; u_cnt = busy_len; end
         else u_cnt--;
      default: if (u_cnt == 0) begin tx_busy = 1'b0; u_phase = 0; end
               else u_cnt--;
    endcase
    drive_srcs();
  endtask

  function automatic logic all_done();
    logic d;
    d = !arb_busy && !tx_busy && (u_phase == 0) && (pend == '0);
    for (int i = 0; i < NR; i++) if (src_q[i].size() != 0) d = 1'b0;
    return d;
  endfunction

  task automatic run_idle(input int max);
    int n;
    n = 0;
    step();
    while (!all_done() && n < max) begin
      step();
      n++;
    end
    chk("drain_within_bound", 32'(all_done()), 32'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_ctrl", 32'(ctrl), 32'd0);
    chk("rst_arb_busy", 32'(arb_busy), 32'd0);
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);
    reset = 1'b0;
    step();
  endtask

  initial begin
    int n;
    reset = 1'b1;
    req_valid = '0;
    req_data = '0;
    req_last = '0;
    uart_state = '0;
    for (int i = 0; i < NR; i++) rdy_cnt[i] = 0;
    drive_srcs();

    // Reset values
    do_reset();

    // Single request, slow UART acknowledge
    start_lat = 700;
    send(0, 8'hA5, 1'b1);
    expect_byte(0, 8'hA5);
    drive_srcs();
    step();
    chk("single_ready_N1", 32'(req_ready), 32'h1);
    chk("single_grant_N1", 32'(grant), 32'h1);
    chk("single_ctrl_N1", 32'(ctrl), 32'h0);
    step();
    chk("single_ctrl_N2", 32'(ctrl), 32'h01);
    chk("single_tx_data", 32'(tx_data), 32'hA5);
    n = 0;
    while (!tx_busy && n < 800) begin
      chk("single_ctrl_held", 32'(ctrl), 32'h01);
      step();
      n++;
    end
    chk("single_busy_seen", 32'(tx_busy), 32'd1);
    step();
    chk("single_ctrl_dropped", 32'(ctrl), 32'h00);
    run_idle(1000);
    chk("single_grant_idle", 32'(grant), 32'h0);
    chk("single_ready_count", 32'(rdy_cnt[0]), 32'd1);
    start_lat = 5;

    // Fairness: all four valid, two bytes each
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NR; i++) begin
        send(i, 8'(8'h10 * (r + 1) + i), 1'b1);
        expect_byte(i, 8'(8'h10 * (r + 1) + i));
      end
    drive_srcs();
    run_idle(2000);

    // Start timeout, then normal service
    ack_en = 1'b0;
    send(1, 8'h5A, 1'b1);
    expect_byte(1, 8'h5A);
    drive_srcs();
    n = 0;
    while (!timeout_err && n < 3000) begin
      step();
      n++;
    end
    chk("timeout_latency", 32'(cyc - start_cyc), 32'd2048);
    chk("timeout_grant_cleared", 32'(grant), 32'd0);
    chk("timeout_idle", 32'(arb_busy), 32'd0);
    chk("timeout_ctrl", 32'(ctrl), 32'd0);
    step();
    chk("timeout_one_cycle", 32'(timeout_err), 32'd0);
    ack_en = 1'b1;
    send(1, 8'h66, 1'b1);
    expect_byte(1, 8'h66);
    drive_srcs();
    run_idle(500);

    // Reset during WAIT with the UART busy
    busy_len = 60;
    send(2, 8'h77, 1'b1);
    expect_byte(2, 8'h77);
    drive_srcs();
    n = 0;
    step();
    while (!(tx_busy && arb_busy && !ctrl[0]) && n < 200) begin
      step();
      n++;
    end
    chk("rwait_reached_wait", 32'(tx_busy && arb_busy && !ctrl[0]), 32'd1);
    send(3, 8'h88, 1'b1);
    drive_srcs();
    reset = 1'b1;
    step();
    chk("rwait_grant", 32'(grant), 32'd0);
    chk("rwait_ctrl", 32'(ctrl), 32'd0);
    chk("rwait_arb_busy", 32'(arb_busy), 32'd0);
    chk("rwait_tx_data", 32'(tx_data), 32'd0);
    reset = 1'b0;
    expect_byte(3, 8'h88);
    n = 0;
    while (tx_busy && n < 200) begin
      step();
      chk("rwait_no_start_busy", 32'(ctrl[0] && tx_busy), 32'd0);
      n++;
    end
    run_idle(500);
    chk("rwait_pending_served", 32'(rdy_cnt[3]), 32'd3);
    busy_len = 20;

    // Message lock versus per-byte round-robin
    do_reset();
    send(2, 8'hC1, 1'b0);
    send(2, 8'hC2, 1'b0);
    send(2, 8'hC3, 1'b1);
    drive_srcs();
    step();
    send(0, 8'hD1, 1'b1);
    send(0, 8'hD2, 1'b1);
    drive_srcs();
`ifdef UART_ARB_LOCK_EN
    expect_byte(2, 8'hC1); expect_byte(2, 8'hC2); expect_byte(2, 8'hC3);
    expect_byte(0, 8'hD1); expect_byte(0, 8'hD2);
`else
    expect_byte(2, 8'hC1); expect_byte(0, 8'hD1); expect_byte(2, 8'hC2);
    expect_byte(0, 8'hD2); expect_byte(2, 8'hC3);
`endif
    run_idle(2000);

    chk("sb_empty_at_end", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
